// File: rtl/tone_pkg.sv
// rtl/tone_pkg.sv - note codes, base-frequency tables and half-period helper; TONE_SHARP_EN selects the 12-note table
package tone_pkg;

`ifdef TONE_SHARP_EN
    localparam int NOTE_W    = 4;
    localparam int NUM_NOTES = 12;
    localparam logic [NOTE_W-1:0] NOTE_A    = 4'd0;
    localparam logic [NOTE_W-1:0] NOTE_AS   = 4'd1;
    localparam logic [NOTE_W-1:0] NOTE_B    = 4'd2;
    localparam logic [NOTE_W-1:0] NOTE_C    = 4'd3;
    localparam logic [NOTE_W-1:0] NOTE_CS   = 4'd4;
    localparam logic [NOTE_W-1:0] NOTE_D    = 4'd5;
    localparam logic [NOTE_W-1:0] NOTE_DS   = 4'd6;
    localparam logic [NOTE_W-1:0] NOTE_E    = 4'd7;
    localparam logic [NOTE_W-1:0] NOTE_F    = 4'd8;
    localparam logic [NOTE_W-1:0] NOTE_FS   = 4'd9;
    localparam logic [NOTE_W-1:0] NOTE_G    = 4'd10;
    localparam logic [NOTE_W-1:0] NOTE_GS   = 4'd11;
    localparam logic [NOTE_W-1:0] NOTE_REST = 4'd12;
`else
    localparam int NOTE_W    = 3;
    localparam int NUM_NOTES = 7;
    localparam logic [NOTE_W-1:0] NOTE_A    = 3'd0;
    localparam logic [NOTE_W-1:0] NOTE_B    = 3'd1;
    localparam logic [NOTE_W-1:0] NOTE_C    = 3'd2;
    localparam logic [NOTE_W-1:0] NOTE_D    = 3'd3;
    localparam logic [NOTE_W-1:0] NOTE_E    = 3'd4;
    localparam logic [NOTE_W-1:0] NOTE_F    = 3'd5;
    localparam logic [NOTE_W-1:0] NOTE_G    = 3'd6;
    localparam logic [NOTE_W-1:0] NOTE_REST = 3'd7;
`endif

    localparam int OCT_W = 2;

    localparam int BASE_FREQ7  [7]  = '{220, 247, 261, 294, 330, 349, 392};
    localparam int BASE_FREQ12 [12] = '{220, 233, 247, 261, 277, 294, 311, 330, 349, 370, 392, 415};

    typedef enum logic {
        VOICE_IDLE = 1'b0,
        VOICE_RUN  = 1'b1
    } voice_state_e;

    function automatic logic is_rest(input logic [NOTE_W-1:0] code);
        return int'(code) >= NUM_NOTES;
    endfunction

    function automatic int note_freq(input logic [NOTE_W-1:0] code);
        if (is_rest(code)) return 0;
`ifdef TONE_SHARP_EN
        return BASE_FREQ12[code];
`else
        return BASE_FREQ7[code];
`endif
    endfunction

    function automatic int half_period(input int clk_hz, input int freq, input int oct);
        if (freq == 0) return 0;
        return clk_hz / (2 * (freq << oct));
    endfunction

endpackage

// File: rtl/tone_voice.sv
// rtl/tone_voice.sv - one square-wave voice: pending request register, IDLE/RUN FSM and half-period counter (note width follows TONE_SHARP_EN)
module tone_voice
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 25000000,
    parameter int CNT_W  = 20
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NOTE_W-1:0] note,
    input  logic [OCT_W-1:0]  octave,
    input  logic              gate,
    output logic              wave,
    output logic              busy
);

    localparam int TAB_N = 2 ** (NOTE_W + OCT_W);

    // Reload constants indexed by {note, octave}; rest codes map to zero and are never loaded.
    logic [CNT_W-1:0] reload_tab [TAB_N];
    for (genvar i = 0; i < TAB_N; i++) begin : g_tab
        localparam int HALF = half_period(CLK_HZ, note_freq(NOTE_W'(i >> OCT_W)), i % 4);
        assign reload_tab[i] = (HALF > 0) ? CNT_W'(HALF - 1) : '0;
    end

    voice_state_e      state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              wave_q, wave_d;
    logic [NOTE_W-1:0] pend_note_q, pend_note_d;
    logic [OCT_W-1:0]  pend_oct_q, pend_oct_d;
    logic              pend_gate_q, pend_gate_d;
    logic              pend_go;
    logic [CNT_W-1:0]  reload;

    always_comb begin
        pend_note_d = note;
        pend_oct_d  = octave;
        pend_gate_d = gate;
        pend_go     = pend_gate_q && !is_rest(pend_note_q);
        reload      = reload_tab[{pend_note_q, pend_oct_q}];
        state_d     = state_q;
        cnt_d       = cnt_q;
        wave_d      = wave_q;
        case (state_q)
            VOICE_IDLE: begin
                wave_d = 1'b0;
                cnt_d  = '0;
                if (pend_go) begin
                    state_d = VOICE_RUN;
                    cnt_d   = reload;
                end
            end
            VOICE_RUN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (pend_go) begin
                    wave_d = ~wave_q;
                    cnt_d  = reload;
                end else begin
                    // Stopping always lands low: a high half finishes, a low half just ends.
                    wave_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = VOICE_IDLE;
                end
            end
            default: state_d = VOICE_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= VOICE_IDLE;
            cnt_q       <= '0;
            wave_q      <= 1'b0;
            pend_note_q <= '0;
            pend_oct_q  <= '0;
            pend_gate_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wave_q      <= wave_d;
            pend_note_q <= pend_note_d;
            pend_oct_q  <= pend_oct_d;
            pend_gate_q <= pend_gate_d;
        end
    end

    assign wave = wave_q;
    assign busy = (state_q == VOICE_RUN);

endmodule

// File: rtl/tone_gen_poly.sv
// rtl/tone_gen_poly.sv - VOICES independent square-wave tones with registered mix count (TONE_SHARP_EN widens note codes)
module tone_gen_poly
    import tone_pkg::*;
#(
    parameter int CLK_HZ = 25000000,
    parameter int VOICES = 4,
    parameter int CNT_W  = 20,
    parameter int MIX_W  = $clog2(VOICES + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NOTE_W*VOICES-1:0] note,
    input  logic [2*VOICES-1:0]      octave,
    input  logic [VOICES-1:0]        gate,
    output logic [VOICES-1:0]        wave,
    output logic [MIX_W-1:0]         mix,
    output logic [VOICES-1:0]        busy
);

    for (genvar v = 0; v < VOICES; v++) begin : g_voice
        tone_voice #(
            .CLK_HZ (CLK_HZ),
            .CNT_W  (CNT_W)
        ) u_voice (
            .clk    (clk),
            .reset  (reset),
            .note   (note[NOTE_W*v +: NOTE_W]),
            .octave (octave[2*v +: 2]),
            .gate   (gate[v]),
            .wave   (wave[v]),
            .busy   (busy[v])
        );
    end

    logic [MIX_W-1:0] mix_q, mix_d;

    always_comb begin
        mix_d = '0;
        for (int v = 0; v < VOICES; v++) begin
            mix_d = mix_d + MIX_W'(wave[v]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mix_q <= '0;
        end else begin
            mix_q <= mix_d;
        end
    end

    assign mix = mix_q;

endmodule

// File: tb/tb_tone_gen_poly.sv
// tb/tb_tone_gen_poly.sv - scoreboard bench for tone_gen_poly at 1 MHz with 4 voices
module tb_tone_gen_poly;
    import tone_pkg::*;

    localparam int CLK_HZ = 1000000;
    localparam int VOICES = 4;
    localparam int CNT_W  = 20;
    localparam int MIX_W  = 3;
    // 1e6/(2*220)=2272, 1e6/(2*440)=1136, 1e6/(2*3136)=159
    localparam int H_A0 = 2272;
    localparam int H_A1 = 1136;
    localparam int H_G3 = 159;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NOTE_W*VOICES-1:0] note;
    logic [2*VOICES-1:0]      octave;
    logic [VOICES-1:0]        gate;
    logic [VOICES-1:0]        wave;
    logic [MIX_W-1:0]         mix;
    logic [VOICES-1:0]        busy;

    tone_gen_poly #(
        .CLK_HZ (CLK_HZ),
        .VOICES (VOICES),
        .CNT_W  (CNT_W)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .note   (note),
        .octave (octave),
        .gate   (gate),
        .wave   (wave),
        .mix    (mix),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int   voice;
        int   at;
        logic val;
    } edge_t;

    edge_t             exp_q[$];
    int                checks = 0;
    int                errors = 0;
    logic [VOICES-1:0] prev_wave;
    logic [VOICES-1:0] exp_wave;

    task automatic check_eq(input string tag, input longint got, input longint want);
        checks++;
        if (got != want) begin
            errors++;
            if (errors <= 50)
                $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, got, want, cyc);
        end
    endtask

    task automatic push_edge(input int v, input int at, input logic val);
        edge_t e;
        e.voice = v;
        e.at    = at;
        e.val   = val;
        exp_q.push_back(e);
    endtask

    task automatic set_voice(input int v, input logic [NOTE_W-1:0] n, input logic [1:0] o, input logic g);
        note[NOTE_W*v +: NOTE_W] = n;
        octave[2*v +: 2]         = o;
        gate[v]                  = g;
    endtask

    task automatic monitor();
        edge_t e;
        int    pc;
        pc = 0;
        for (int v = 0; v < VOICES; v++) pc += int'(exp_wave[v]);
        check_eq("mix", mix, reset ? 0 : pc);
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            e = exp_q.pop_front();
            check_eq($sformatf("edge_missed_v%0d", e.voice), cyc, e.at);
            exp_wave[e.voice] = e.val;
        end
        for (int v = 0; v < VOICES; v++) begin
            if (wave[v] !== prev_wave[v]) begin
                if (exp_q.size() == 0) begin
                    check_eq($sformatf("edge_unexpected_v%0d", v), wave[v], prev_wave[v]);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("edge_voice", v, e.voice);
                    check_eq($sformatf("edge_cycle_v%0d", v), cyc, e.at);
                    check_eq($sformatf("edge_level_v%0d", v), wave[v], e.val);
                    exp_wave[e.voice] = e.val;
                end
            end
        end
        prev_wave = wave;
    endtask

    task automatic run_until(input int target);
        while (cyc < target) begin
            @(negedge clk);
            monitor();
        end
    endtask

    task automatic run(input int n);
        run_until(cyc + n);
    endtask

    initial begin
        int d, r, r4, t, first, rr;
        reset    = 1'b1;
        note     = '0;
        octave   = '0;
        gate     = '0;
        exp_wave = '0;
        repeat (3) @(negedge clk);
        prev_wave = wave;
        check_eq("rst_wave", wave, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_mix", mix, 0);
        reset = 1'b0;
        run(5);
        check_eq("idle_busy", busy, 0);

        // Single voice A, octave 0
        d = cyc;
        set_voice(0, NOTE_A, 2'd0, 1'b1);
        r = d + 2 + H_A0;
        for (int k = 0; k < 4; k++) push_edge(0, r + k * H_A0, (k % 2) == 0);
        run(1);
        check_eq("s1_sampled_busy", busy[0], 0);
        run(1);
        check_eq("s1_run_busy", busy[0], 1);
        check_eq("s1_run_wave", wave[0], 0);
        run_until(r - 1);
        check_eq("s1_pre_rise", wave[0], 0);

        // Octave retune mid-half; only the last pending value counts
        run_until(r + 3 * H_A0 + 500);
        set_voice(0, NOTE_A, 2'd3, 1'b1);
        run(500);
        set_voice(0, NOTE_A, 2'd1, 1'b1);
        push_edge(0, r + 4 * H_A0, 1'b1);
        push_edge(0, r + 4 * H_A0 + H_A1, 1'b0);
        push_edge(0, r + 4 * H_A0 + 2 * H_A1, 1'b1);
        r4 = r + 4 * H_A0 + 2 * H_A1;

        // Gate drop while high
        run_until(r4 + 300);
        set_voice(0, NOTE_A, 2'd1, 1'b0);
        t = r4 + H_A1;
        push_edge(0, t, 1'b0);
        run_until(t - 1);
        check_eq("s3_hold_busy", busy[0], 1);
        check_eq("s3_hold_wave", wave[0], 1);
        run(1);
        check_eq("s3_stop_busy", busy[0], 0);
        check_eq("s3_stop_wave", wave[0], 0);
        run(3 * H_A1);
        check_eq("s3_idle_busy", busy[0], 0);

        // Rest code with gate high
        set_voice(0, NOTE_REST, 2'd0, 1'b1);
        run(3000);
        check_eq("rest_busy", busy, 0);
        check_eq("rest_wave", wave, 0);
        set_voice(0, NOTE_A, 2'd0, 1'b0);
        run(2);

        // All voices on G octave 3 in the same cycle
        d = cyc;
        for (int v = 0; v < VOICES; v++) set_voice(v, NOTE_G, 2'd3, 1'b1);
        first = d + 2 + H_G3;
        for (int k = 0; k < 5; k++)
            for (int v = 0; v < VOICES; v++) push_edge(v, first + k * H_G3, (k % 2) == 0);
        for (int v = 0; v < VOICES; v++) push_edge(v, first + 5 * H_G3, 1'b0);
        push_edge(0, first + 6 * H_G3, 1'b1);
        push_edge(1, first + 6 * H_G3, 1'b1);
        run_until(first + 4 * H_G3 + 1);
        check_eq("s4_mix_all", mix, 4);
        run(19);
        gate[2] = 1'b0;
        gate[3] = 1'b0;
        run_until(first + 5 * H_G3 + 1);
        check_eq("s4_mix_none", mix, 0);
        check_eq("s4_busy_two", busy, 4'b0011);

        // Reset mid-period with two voices running
        run_until(first + 6 * H_G3 + 40);
        reset = 1'b1;
        gate  = '0;
        d = cyc;
        push_edge(0, d + 1, 1'b0);
        push_edge(1, d + 1, 1'b0);
        run(1);
        check_eq("s6_rst_wave", wave, 0);
        check_eq("s6_rst_busy", busy, 0);
        run(1);
        check_eq("s6_rst_mix", mix, 0);
        run(2);

        // Restart after reset matches the first start-up
        reset = 1'b0;
        d = cyc;
        set_voice(0, NOTE_A, 2'd0, 1'b1);
        rr = d + 2 + H_A0;
        push_edge(0, rr, 1'b1);
        run_until(rr - 1);
        check_eq("s6_pre_rise", wave[0], 0);
        run(1);
        check_eq("s6_rise", wave[0], 1);
        run(20);
        check_eq("s6_mix_one", mix, 1);

        check_eq("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
